// File: rtl/nvram_backup_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : nvram_backup_sequencer
// Purpose  : Sits between the CPU and a 256x8 NVRAM array. When idle, CPU
//            accesses pass straight through to the array. On request it runs
//            a 512-clock sequence that either copies the backup RAM into the
//            array (RECALL) or copies the array into the backup RAM (STORE).
//            Each byte takes two clocks: phase A presents the read address,
//            phase B writes the data returned one clock later.
// Ports    : clk, RESETn              clock, async active-low reset
//            NVRAMn, WRphi2n, BA,
//            data_to_nvram            CPU select/strobe/address/write data
//            DCOKn, STORE, RECALLn    power-good, store and recall requests
//            nv_addr, nv_din, nv_we_n,
//            data_from_nvram          NVRAM array port (read latency 1 clk)
//            bk_addr, bk_d, bk_we,
//            bk_q                     backup RAM port (read latency 1 clk)
//            busy, dirty, store_done,
//            write_lost               status outputs
// Options  : NVRAM_AUTORECALL_EN - when defined, leaving reset starts a
//            RECALL sequence at byte 0 (busy resets to 1).
// Revision : 1.0 - initial release
// ============================================================================
module nvram_backup_sequencer (
    input  logic       clk,
    input  logic       RESETn,
    input  logic       NVRAMn,
    input  logic       WRphi2n,
    input  logic [7:0] BA,
    input  logic [7:0] data_to_nvram,
    input  logic       DCOKn,
    input  logic       STORE,
    input  logic       RECALLn,
    output logic [7:0] nv_addr,
    output logic [7:0] nv_din,
    output logic       nv_we_n,
    input  logic [7:0] data_from_nvram,
    output logic [7:0] bk_addr,
    output logic [7:0] bk_d,
    output logic       bk_we,
    input  logic [7:0] bk_q,
    output logic       busy,
    output logic       dirty,
    output logic       store_done,
    output logic       write_lost
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_RECALL = 2'd1;
    localparam logic [1:0] c_STORE  = 2'd2;

`ifdef NVRAM_AUTORECALL_EN
    localparam logic [1:0] c_RESET_STATE = c_RECALL;
`else
    localparam logic [1:0] c_RESET_STATE = c_IDLE;
`endif

    localparam logic [7:0] c_LAST_BYTE = 8'hFF;

    logic [1:0] r_state;
    logic [7:0] r_cnt;
    logic       r_phase;        // 0 = phase A (address), 1 = phase B (write)
    logic       r_recall_n_q;
    logic       r_store_q;
    logic       r_dirty;
    logic       r_store_done;
    logic       r_write_lost;

    logic [1:0] w_state_nxt;
    logic [7:0] w_cnt_nxt;
    logic       w_phase_nxt;
    logic       w_last_byte;
    logic       w_cpu_wr;
    logic       w_recall_fall;
    logic       w_store_rise;

    assign w_cpu_wr      = ~NVRAMn & ~WRphi2n;
    assign w_recall_fall = r_recall_n_q & ~RECALLn;
    assign w_store_rise  = STORE & ~r_store_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            r_state      <= c_RESET_STATE;
            r_cnt        <= 8'h00;
            r_phase      <= 1'b0;
            r_recall_n_q <= 1'b1;
            r_store_q    <= 1'b0;
            r_dirty      <= 1'b0;
            r_store_done <= 1'b0;
            r_write_lost <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_phase      <= w_phase_nxt;
            r_recall_n_q <= RECALLn;
            r_store_q    <= STORE;
            r_store_done <= w_last_byte && (r_state == c_STORE);

            // A CPU write in IDLE always marks the array dirty. Finishing a
            // STORE clears it, except when a CPU write lands in that very
            // clock; finishing a RECALL leaves the array matching the backup.
            if ((r_state == c_IDLE) && w_cpu_wr)
                r_dirty <= 1'b1;
            else if (w_last_byte && (r_state == c_STORE) && !w_cpu_wr)
                r_dirty <= 1'b0;
            else if (w_last_byte && (r_state == c_RECALL))
                r_dirty <= 1'b0;

            if ((r_state != c_IDLE) && w_cpu_wr)
                r_write_lost <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_phase_nxt = r_phase;
        w_last_byte = 1'b0;
        nv_addr     = r_cnt;
        nv_din      = 8'h00;
        nv_we_n     = 1'b1;
        bk_addr     = r_cnt;
        bk_d        = data_from_nvram;
        bk_we       = 1'b0;

        case (r_state)
            c_IDLE: begin
                nv_addr = BA;
                nv_din  = data_to_nvram;
                // Gated by reset so the array is never written while held.
                nv_we_n = ~(w_cpu_wr & RESETn);
                // Recall has priority over a simultaneous store request.
                if (w_recall_fall)
                    w_state_nxt = c_RECALL;
                else if (w_store_rise && !DCOKn)
                    w_state_nxt = c_STORE;
            end

            c_RECALL, c_STORE: begin
                w_phase_nxt = ~r_phase;
                if (r_phase) begin
                    w_cnt_nxt = r_cnt + 8'd1;   // wraps 0xFF -> 0x00 on exit
                    if (r_cnt == c_LAST_BYTE) begin
                        w_last_byte = 1'b1;
                        w_state_nxt = c_IDLE;
                    end
                end

                if (r_state == c_RECALL) begin
                    // Phase B writes the backup byte fetched during phase A.
                    nv_din  = bk_q;
                    nv_we_n = ~r_phase;
                end else begin
                    // Phase B saves the array byte fetched during phase A.
                    bk_we = r_phase;
                end
            end

            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    assign busy       = (r_state != c_IDLE);
    assign dirty      = r_dirty;
    assign store_done = r_store_done;
    assign write_lost = r_write_lost;

endmodule
`default_nettype wire
